// File: rtl/rgb_downconvert.sv
// rgb_downconvert: streaming RGB888 -> RGB565 converter with a two-stage
// valid/ready pipeline and per-channel rounding with saturation.
// Optional ordered dither: define RGB_DOWNCONVERT_DITHER_EN to replace the
// fixed rounding offset with a 2x2 Bayer threshold indexed by pixel parity.
module rgb_downconvert #(
  parameter bit ROUND           = 1'b1,
  parameter bit BYPASS_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] in_rgb888,
  input  logic        in_sof,
  input  logic        in_eol,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_rgb565,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned IN_W  = 24;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned CH_W  = 8;
  localparam int unsigned OFF_W = 3;

  // Add the offset in 9 bits, shift to 5 bits, clamp to 31 on overflow.
  function automatic logic [4:0] conv5(input logic [CH_W-1:0] v,
                                       input logic [OFF_W-1:0] off);
    logic [CH_W:0] s;
    logic [5:0]    q;
    s = {1'b0, v} + 9'(off);
    q = s[8:3];
    if (s[8] || (q > 6'd31)) conv5 = 5'd31;
    else                     conv5 = q[4:0];
  endfunction

  // Add the offset in 9 bits, shift to 6 bits, clamp to 63 on overflow.
  function automatic logic [5:0] conv6(input logic [CH_W-1:0] v,
                                       input logic [OFF_W-1:0] off);
    logic [CH_W:0] s;
    logic [6:0]    q;
    s = {1'b0, v} + 9'(off);
    q = s[8:2];
    if (s[8] || (q > 7'd63)) conv6 = 6'd63;
    else                     conv6 = q[5:0];
  endfunction

  logic [CH_W-1:0] r8, g8, b8;
  logic [OUT_W-1:0] pix565;

  logic settle;
  logic x_par, y_par, f_par;

  logic             s1_valid;
  logic [OUT_W-1:0] s1_rgb;
  logic             s1_sof;
  logic             s1_eol;

  logic s2_load;
  logic s1_adv;
  logic in_fire;

  assign r8 = in_rgb888[IN_W-1:16];
  assign g8 = in_rgb888[15:8];
  assign b8 = in_rgb888[7:0];

  // Handshake: S2 takes a word when empty or draining; S1 moves when S2 does.
  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_load;
  assign in_ready = !settle && s1_adv;
  assign in_fire  = in_valid && in_ready;

`ifdef RGB_DOWNCONVERT_DITHER_EN
  logic             x_cur, y_cur, f_cur;
  logic [1:0]       idx;
  logic [OFF_W-1:0] rb_off, g_off;

  // Parity of the pixel on the input; sof pixels sit at x=0,y=0 of the new
  // frame, whose parity is the pre-toggle f_par (later pixels see ~f_par).
  always_comb begin
    x_cur  = in_sof ? 1'b0 : x_par;
    y_cur  = in_sof ? 1'b0 : y_par;
    f_cur  = in_sof ? f_par : ~f_par;
    idx    = {y_cur ^ f_cur, x_cur};
    rb_off = 3'd0;
    g_off  = 3'd0;
    case (idx)
      2'd0: begin rb_off = 3'd0; g_off = 3'd0; end
      2'd1: begin rb_off = 3'd4; g_off = 3'd2; end
      2'd2: begin rb_off = 3'd6; g_off = 3'd3; end
      default: begin rb_off = 3'd2; g_off = 3'd1; end
    endcase
  end

  // Dithered conversion with saturation.
  always_comb begin
    pix565 = {conv5(r8, rb_off), conv6(g8, g_off), conv5(b8, rb_off)};
  end
`else
  // Fixed round-to-nearest with saturation, or plain truncation.
  always_comb begin
    if (ROUND) pix565 = {conv5(r8, 3'd4), conv6(g8, 3'd2), conv5(b8, 3'd4)};
    else       pix565 = {r8[7:3], g8[7:2], b8[7:3]};
  end
`endif

  // One-cycle input hold-off after reset release when configured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) settle <= BYPASS_ON_RESET;
    else       settle <= 1'b0;
  end

  // Pixel/line/frame parity, advanced on every accepted pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_par <= 1'b0;
      y_par <= 1'b0;
      f_par <= 1'b0;
    end else if (in_fire) begin
      if (in_sof) begin
        f_par <= ~f_par;
        x_par <= ~in_eol;
        y_par <= in_eol;
      end else if (in_eol) begin
        x_par <= 1'b0;
        y_par <= ~y_par;
      end else begin
        x_par <= ~x_par;
      end
    end
  end

  // Stage 1: converted pixel plus sideband.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_rgb   <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_rgb <= pix565;
        s1_sof <= in_sof;
        s1_eol <= in_eol;
      end
    end
  end

  // Stage 2: output register, held while downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_rgb565 <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_rgb565 <= s1_rgb;
        out_sof    <= s1_sof;
        out_eol    <= s1_eol;
      end
    end
  end

endmodule

// File: tb/tb_rgb_downconvert.sv
// Bench for rgb_downconvert: scoreboard of expected pixels pushed on input
// accept and popped on output transfer; a second instance (ROUND=0,
// BYPASS_ON_RESET=1) runs in lockstep to cover truncation and settle.
module tb_rgb_downconvert;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] in_rgb888 = '0;
  logic        in_sof = 1'b0;
  logic        in_eol = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_rgb565;
  logic        out_sof, out_eol, out_valid;
  logic        out_ready = 1'b1;

  logic        t_in_ready;
  logic [15:0] t_out_rgb565;
  logic        t_out_sof, t_out_eol, t_out_valid;

  always #5 clk = ~clk;

  rgb_downconvert u_dut (
    .clk(clk), .reset(reset),
    .in_rgb888(in_rgb888), .in_sof(in_sof), .in_eol(in_eol),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_rgb565(out_rgb565), .out_sof(out_sof), .out_eol(out_eol),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  rgb_downconvert #(.ROUND(1'b0), .BYPASS_ON_RESET(1'b1)) u_trunc (
    .clk(clk), .reset(reset),
    .in_rgb888(in_rgb888), .in_sof(in_sof), .in_eol(in_eol),
    .in_valid(in_valid), .in_ready(t_in_ready),
    .out_rgb565(t_out_rgb565), .out_sof(t_out_sof), .out_eol(t_out_eol),
    .out_valid(t_out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] t;
    logic        sof;
    logic        eol;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=0x%0h want=0x%0h @%0t", tag, got, want, $time);
    end
  endtask

  // Reference conversion in integer arithmetic.
  function automatic logic [15:0] model(input logic [23:0] p, input bit rnd, input int unsigned idx);
    int ro, go, r, g, b;
`ifdef RGB_DOWNCONVERT_DITHER_EN
    int rbt[4] = '{0, 4, 6, 2};
    int gt[4]  = '{0, 2, 3, 1};
    ro = rbt[idx];
    go = gt[idx];
`else
    ro = rnd ? 4 : 0;
    go = rnd ? 2 : 0;
    if (idx > 3) ro = 0;
`endif
    r = (int'(p[23:16]) + ro) / 8;
    g = (int'(p[15:8]) + go) / 4;
    b = (int'(p[7:0]) + ro) / 8;
    if (r > 31) r = 31;
    if (g > 63) g = 63;
    if (b > 31) b = 31;
    return {5'(r), 6'(g), 5'(b)};
  endfunction

  // Monitor state
  logic [31:0] frames;
  logic        mx, my, px, py, pf;
  logic        hold;
  logic [17:0] held;
  exp_t        e_pop, e_push;

  // Sample both sides on the falling edge: check holds, pop outputs, push accepts.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      frames = '0;
      mx = 1'b0;
      my = 1'b0;
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {14'd0, out_rgb565, out_sof, out_eol}, {14'd0, held});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e_pop = sb.pop_front();
          check("rgb565", {16'd0, out_rgb565}, {16'd0, e_pop.a});
          check("rgb565_trunc", {16'd0, t_out_rgb565}, {16'd0, e_pop.t});
          check("trunc_valid", {31'd0, t_out_valid}, 32'd1);
          check("out_sof", {31'd0, out_sof}, {31'd0, e_pop.sof});
          check("out_eol", {31'd0, out_eol}, {31'd0, e_pop.eol});
        end
      end
      hold = out_valid && !out_ready;
      held = {out_rgb565, out_sof, out_eol};
      if (in_valid && in_ready) begin
        if (in_sof) begin
          frames = frames + 1;
          px = 1'b0;
          py = 1'b0;
        end else begin
          px = mx;
          py = my;
        end
        pf = ~frames[0];
        e_push.a   = model(in_rgb888, 1'b1, {30'd0, py ^ pf, px});
        e_push.t   = model(in_rgb888, 1'b0, {30'd0, py ^ pf, px});
        e_push.sof = in_sof;
        e_push.eol = in_eol;
        sb.push_back(e_push);
        n_acc++;
        if (in_sof && in_eol) begin mx = 1'b0; my = 1'b1; end
        else if (in_sof)      begin mx = 1'b1; my = 1'b0; end
        else if (in_eol)      begin mx = 1'b0; my = ~my; end
        else                  mx = ~mx;
      end
    end
  end

  // Present one pixel from posedge+1 until accepted; returns at posedge+1.
  task automatic send_pixel(input logic [23:0] p, input logic s, input logic e);
    int waits = 0;
    in_rgb888 = p;
    in_sof    = s;
    in_eol    = e;
    in_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 200) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_rgb", {16'd0, out_rgb565}, 32'd0);
    check("rst_out_sb", {30'd0, out_sof, out_eol}, 32'd0);
    check("rst_trunc_valid", {31'd0, t_out_valid}, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);
    check("settle_ready_low", {31'd0, t_in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("settle_ready_high", {31'd0, t_in_ready}, 32'd1);
  endtask

  // After an accept into an empty pipe: valid appears on the second edge only.
  task automatic lat_check();
    @(negedge clk);
    check("lat_1clk", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_2clk", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("lat_alone", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [23:0] basic[5] = '{24'hFFFFFF, 24'h000000, 24'h808080, 24'hFCFEFC, 24'h070307};
  bit rnd_done;
  int acc0;

  initial begin
    #2;
    assert_reset();
    repeat (2) @(posedge clk);
    release_reset();

    // First pixel latency, then the directed values back to back.
    send_pixel(basic[0], 1'b0, 1'b0);
    lat_check();
    for (int i = 0; i < 5; i++) send_pixel(basic[i], 1'b0, 1'b0);
    drain();

    // Stall from empty: exactly two accepted, then in_ready low.
    acc0 = n_acc;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_pixel(24'($urandom), 1'b0, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        #1;
        check("stall_accepts", 32'(n_acc - acc0), 32'd2);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Two 4x2 frames of constant 0x040404, then a 4x2 frame of random data.
    for (int f = 0; f < 3; f++)
      for (int y = 0; y < 2; y++)
        for (int x = 0; x < 4; x++)
          send_pixel((f < 2) ? 24'h040404 : 24'($urandom),
                     (x == 0) && (y == 0), x == 3);
    drain();

    // Single-pixel lines: line parity flips on every pixel.
    send_pixel(24'h040404, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_pixel(24'h040404, 1'b0, 1'b1);
    send_pixel(24'h0C0C0C, 1'b0, 1'b0);
    send_pixel(24'h0C0C0C, 1'b0, 1'b0);
    drain();

    // Random data and sideband under random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++)
          send_pixel(24'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two pixels in flight, then one pixel alone.
    send_pixel(24'h123456, 1'b0, 1'b0);
    send_pixel(24'h654321, 1'b0, 1'b0);
    #1;
    check("inflight_valid", {31'd0, out_valid}, 32'd1);
    assert_reset();
    release_reset();
    send_pixel(24'hA5A5A5, 1'b0, 1'b0);
    lat_check();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
